// File: rtl/rv32i_irq_pkg.sv
// rtl/rv32i_irq_pkg.sv - shared types, constants and cause encoding for the interrupt controller
package rv32i_irq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } irq_state_e;

    localparam int unsigned CAUSE_IRQ_BASE = 16;
    localparam int unsigned MCAUSE_INT_BIT = 31;

    function automatic logic [31:0] make_cause(input logic [4:0] id);
        logic [31:0] cause;
        cause = 32'(CAUSE_IRQ_BASE) + {27'd0, id};
        cause[MCAUSE_INT_BIT] = 1'b1;
        return cause;
    endfunction

endpackage

// File: rtl/rv32i_sync_edge.sv
// rtl/rv32i_sync_edge.sv - multi-flop synchroniser with rising-edge detect for one interrupt line
module rv32i_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Combinational so the pending register sees the edge one cycle after the last sync flop.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rv32i_irq_controller.sv
// rtl/rv32i_irq_controller.sv - pending latch, fixed-priority arbiter and trap handshake FSM
module rv32i_irq_controller
    import rv32i_irq_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_enable,
    input  logic               mstatus_mie,
    input  logic               trap_ack,
    input  logic               trap_complete,
    output logic               mei_exception,
    output logic [31:0]        mei_cause,
    output logic [NUM_SRC-1:0] irq_pending,
    output logic               busy
);

    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_clr;
    logic [NUM_SRC-1:0] candidates;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    id_d;
    irq_state_e         state_q;
    irq_state_e         state_d;
    logic               ack_take;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        rv32i_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk  (clk),
            .rst  (rst),
            .d    (irq_src[g]),
            .rise (rise[g])
        );
    end

    assign candidates = pending_q & irq_enable;
    assign ack_take   = (state_q == REQ) && trap_ack;

    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (candidates[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        pending_clr = '0;
        if (ack_take) begin
            pending_clr[id_q] = 1'b1;
        end
    end

    // A fresh edge on the same cycle as the clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~pending_clr) | rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (mstatus_mie && (|candidates)) begin
                    id_d    = win_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (trap_ack) begin
                    state_d = ACTIVE;
                end else if (!mstatus_mie || !irq_enable[id_q]) begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (trap_complete) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mei_exception = (state_q == REQ);
    assign mei_cause     = (state_q == REQ) ? make_cause(5'(id_q)) : 32'd0;
    assign busy          = (state_q == REQ) || (state_q == ACTIVE);
    assign irq_pending   = pending_q;

endmodule
